// File: rtl/chip8_blitter.sv
// CHIP-8 sprite blitter: XOR-draws sprite rows into byte-packed VRAM and clears VRAM.
// Optional collision detection is enabled by defining CHIP8_BLITTER_COLLISION_EN.
module chip8_blitter #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              draw_valid_in,
    output logic              draw_ready_out,
    input  logic [ADDR_W-1:0] sprite_addr_in,
    input  logic [7:0]        sprite_x_in,
    input  logic [6:0]        sprite_y_in,
    input  logic [3:0]        sprite_height_in,
    input  logic              wrap_in,
    input  logic              clear_in,
    output logic              done_out,
    output logic              collision_out,
    output logic              mem_valid_out,
    input  logic              mem_ready_in,
    output logic              mem_we_out,
    output logic              mem_type_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [7:0]        mem_data_out,
    input  logic              mem_rvalid_in,
    input  logic [7:0]        mem_data_in
);
    localparam int XB_N   = WIDTH / 8;
    localparam int VBYTES = XB_N * HEIGHT;

    typedef enum logic [2:0] {IDLE, FETCH, RD_L, RD_R, WR_L, WR_R, CLEAR} state_t;

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] saddr_q, saddr_d;
    logic [6:0]        x0_q, x0_d, y_q, y_d;
    logic [3:0]        row_q, row_d, height_q, height_d;
    logic              wrap_q, wrap_d;
    logic [15:0]       line_q, line_d;
    logic              mem_valid_q, mem_valid_d, mem_we_q, mem_we_d, mem_type_q, mem_type_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_data_q, mem_data_d;
    logic              done_q, done_d;

    logic              xfer, rdata_ok, skip_right, last_row, next_row, y_hit;
    logic [3:0]        xb_left, xb_right;
    logic [6:0]        y_inc;
    logic [ADDR_W-1:0] vaddr_left, vaddr_right;

    // A beat moves when mem_valid_out && mem_ready_in; request fields hold until then.
    // A read beat is followed by a wait for mem_rvalid_in before any new beat is raised.
    assign xfer           = mem_valid_q && mem_ready_in;
    assign rdata_ok       = pend_q && mem_rvalid_in;
    assign draw_ready_out = (state_q == IDLE) && !clear_in;

    assign xb_left     = 4'(x0_q >> 3);
    assign xb_right    = (xb_left == 4'(XB_N - 1)) ? 4'd0 : xb_left + 4'd1;
    assign vaddr_left  = ADDR_W'(y_q) * ADDR_W'(XB_N) + ADDR_W'(xb_left);
    assign vaddr_right = ADDR_W'(y_q) * ADDR_W'(XB_N) + ADDR_W'(xb_right);
    assign skip_right  = (x0_q[2:0] == 3'd0) || (!wrap_q && xb_left == 4'(XB_N - 1));
    assign y_inc       = y_q + 7'd1;
    assign y_hit       = (y_inc == 7'(HEIGHT));
    assign last_row    = (5'(row_q) + 5'd1 == 5'(height_q)) || (!wrap_q && y_hit);

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        saddr_d     = saddr_q;
        x0_d        = x0_q;
        y_d         = y_q;
        row_d       = row_q;
        height_d    = height_q;
        wrap_d      = wrap_q;
        line_d      = line_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_type_d  = mem_type_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        done_d      = 1'b0;
        next_row    = 1'b0;

        if (xfer) begin
            mem_valid_d = 1'b0;
            if (!mem_we_q) pend_d = 1'b1;
        end
        if (rdata_ok) pend_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear_in) begin
                    state_d     = CLEAR;
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_type_d  = 1'b1;
                    mem_addr_d  = '0;
                    mem_data_d  = 8'h00;
                end else if (draw_valid_in) begin
                    // WIDTH and HEIGHT are powers of two, so masking is the modulo
                    saddr_d  = sprite_addr_in;
                    x0_d     = 7'(sprite_x_in) & 7'(WIDTH - 1);
                    y_d      = sprite_y_in & 7'(HEIGHT - 1);
                    row_d    = 4'd0;
                    height_d = sprite_height_in;
                    wrap_d   = wrap_in;
                    if (sprite_height_in == 4'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = FETCH;
                        mem_valid_d = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_type_d  = 1'b0;
                        mem_addr_d  = sprite_addr_in;
                        mem_data_d  = 8'h00;
                    end
                end
            end
            FETCH: if (rdata_ok) begin
                line_d      = {mem_data_in, 8'h00} >> x0_q[2:0];
                state_d     = RD_L;
                mem_valid_d = 1'b1;
                mem_we_d    = 1'b0;
                mem_type_d  = 1'b1;
                mem_addr_d  = vaddr_left;
            end
            RD_L: if (rdata_ok) begin
                state_d     = WR_L;
                mem_valid_d = 1'b1;
                mem_we_d    = 1'b1;
                mem_data_d  = line_q[15:8] ^ mem_data_in;
            end
            WR_L: if (xfer) begin
                if (skip_right) begin
                    next_row = 1'b1;
                end else begin
                    state_d     = RD_R;
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = vaddr_right;
                    mem_data_d  = 8'h00;
                end
            end
            RD_R: if (rdata_ok) begin
                state_d     = WR_R;
                mem_valid_d = 1'b1;
                mem_we_d    = 1'b1;
                mem_data_d  = line_q[7:0] ^ mem_data_in;
            end
            WR_R: if (xfer) next_row = 1'b1;
            CLEAR: if (xfer) begin
                if (mem_addr_q == ADDR_W'(VBYTES - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    mem_valid_d = 1'b1;
                    mem_addr_d  = mem_addr_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (next_row) begin
            if (last_row) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                row_d       = row_q + 4'd1;
                y_d         = y_hit ? 7'd0 : y_inc;
                state_d     = FETCH;
                mem_valid_d = 1'b1;
                mem_we_d    = 1'b0;
                mem_type_d  = 1'b0;
                mem_addr_d  = saddr_q + ADDR_W'(row_q + 4'd1);
                mem_data_d  = 8'h00;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            saddr_q     <= '0;
            x0_q        <= '0;
            y_q         <= '0;
            row_q       <= '0;
            height_q    <= '0;
            wrap_q      <= 1'b0;
            line_q      <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_type_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            saddr_q     <= saddr_d;
            x0_q        <= x0_d;
            y_q         <= y_d;
            row_q       <= row_d;
            height_q    <= height_d;
            wrap_q      <= wrap_d;
            line_q      <= line_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_type_q  <= mem_type_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            done_q      <= done_d;
        end
    end

    assign mem_valid_out = mem_valid_q;
    assign mem_we_out    = mem_we_q;
    assign mem_type_out  = mem_type_q;
    assign mem_addr_out  = mem_addr_q;
    assign mem_data_out  = mem_data_q;
    assign done_out      = done_q;

`ifdef CHIP8_BLITTER_COLLISION_EN
    logic coll_q, coll_d;

    // A hit is any sprite bit landing on a lit VRAM bit of the byte just read
    always_comb begin
        coll_d = coll_q;
        if (draw_ready_out && draw_valid_in)
            coll_d = 1'b0;
        else if (rdata_ok && state_q == RD_L && |(line_q[15:8] & mem_data_in))
            coll_d = 1'b1;
        else if (rdata_ok && state_q == RD_R && |(line_q[7:0] & mem_data_in))
            coll_d = 1'b1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) coll_q <= 1'b0;
        else        coll_q <= coll_d;
    end

    assign collision_out = coll_q;
`else
    assign collision_out = 1'b0;
`endif
endmodule

// File: doc/chip8_blitter.md
CHIP8_BLITTER -- requirements
Module: chip8_blitter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, display width in pixels (64 or 128, multiple of 8).
REQ-002 SHALL have parameter HEIGHT, default 32, display height in pixels (32 or 64).
REQ-003 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-004 Ports (name direction width meaning):
 clk_in  in  1  sole clock.
 rst_in  in  1  asynchronous, active-high reset.
 draw_valid_in  in  1  draw request.
 draw_ready_out  out  1  high = draw request can be accepted this cycle.
 sprite_addr_in  in  ADDR_W  RAM address of first sprite byte.
 sprite_x_in  in  8  start column.
 sprite_y_in  in  7  start row.
 sprite_height_in  in  4  rows to draw, 0..15.
 wrap_in  in  1  1 = wrap at screen edges, 0 = clip.
 clear_in  in  1  clear whole framebuffer.
 done_out  out  1  one-cycle pulse when a draw or clear finishes.
 collision_out  out  1  1 = last draw turned at least one pixel off.
 mem_valid_out  out  1  request beat valid.
 mem_ready_in  in  1  memory accepts a beat.
 mem_we_out  out  1  1 = write, 0 = read.
 mem_type_out  out  1  0 = RAM (sprite), 1 = VRAM.
 mem_addr_out  out  ADDR_W  beat address.
 mem_data_out  out  8  write data.
 mem_rvalid_in  in  1  read data valid.
 mem_data_in  in  8  read data.

Function
REQ-005 A beat SHALL transfer on a cycle with mem_valid_out && mem_ready_in; mem_valid_out and all mem_* request outputs SHALL be held stable until the beat transfers.
REQ-006 The block SHALL have at most one read outstanding and SHALL issue no new beat until mem_rvalid_in returns the data for that read.
REQ-007 States SHALL be IDLE, FETCH, RD_L, RD_R, WR_L, WR_R, CLEAR; draw_ready_out = (state==IDLE) && !clear_in.
REQ-008 In IDLE, clear_in SHALL take priority over draw_valid_in; clear_in outside IDLE SHALL be ignored.
REQ-009 On draw accept, inputs SHALL be latched; x0 = sprite_x_in mod WIDTH, y0 = sprite_y_in mod HEIGHT; collision SHALL clear to 0.
REQ-010 Row r (0..height-1): FETCH reads RAM at sprite_addr+r; line = {byte,8'h00} >> x0[2:0]; row y = y0+r.
REQ-011 VRAM address SHALL be y*(WIDTH/8)+xb, with left xb = x0>>3 and right xb = (xb_left+1) mod WIDTH/8.
REQ-012 Each row SHALL read-modify-write the left byte (RD_L, WR_L), then the right byte (RD_R, WR_R), writing line XOR VRAM.
REQ-013 The right-byte read and write SHALL be skipped when x0[2:0]==0, or when wrap_in==0 and xb_left==WIDTH/8-1.
REQ-014 When wrap_in==1, y SHALL wrap mod HEIGHT; when wrap_in==0, rows with y0+r >= HEIGHT SHALL be skipped with no beats, and the draw SHALL end.
REQ-015 After the last row, the block SHALL return to IDLE and pulse done_out for exactly one cycle.
REQ-016 sprite_height_in==0 SHALL produce no beats and a done_out pulse on the cycle after accept, with collision_out=0.
REQ-017 CLEAR SHALL write 8'h00 to VRAM addresses 0..WIDTH/8*HEIGHT-1 in ascending order, then pulse done_out and return to IDLE.
REQ-018 collision_out SHALL be registered and valid from the done_out pulse until the next draw accept; a clear SHALL leave it unchanged.

Reset
REQ-019 rst_in SHALL immediately force state=IDLE, mem_valid_out=0, mem_we_out=0, mem_type_out=0, mem_addr_out=0, mem_data_out=0, done_out=0, collision_out=0.
REQ-020 Reset mid-draw or mid-clear SHALL abandon the operation: no further beats, no done_out pulse, and no memory state restored.

Configuration
REQ-021 With CHIP8_BLITTER_COLLISION_EN defined, collision SHALL be set when any (sprite bit & VRAM bit) is nonzero in any byte written.
REQ-022 Without CHIP8_BLITTER_COLLISION_EN, collision_out SHALL be constant 0 and no collision logic SHALL be present; all other behaviour is unchanged.

Verification
REQ-023 Draw x=0, y=0, h=1, sprite 8'hF0, VRAM zero -> exactly 1 read RAM, 1 read VRAM 0, 1 write VRAM 0 = 8'hF0, done pulse, collision 0.
REQ-024 Same draw repeated -> VRAM 0 = 8'h00, collision_out=1 (0 when the macro is undefined).
REQ-025 WIDTH=64, x=60, y=31, h=2, wrap=1, sprite 8'hFF -> writes at addresses 255=8'h0F, 248=8'hF0, 7=8'h0F, 0=8'hF0.
REQ-026 Same stimulus as REQ-025 with wrap=0 -> single write at address 255=8'h0F; no other beats.
REQ-027 clear_in with mem_ready_in toggling 50% -> 256 writes of 8'h00 at addresses 0..255 in order, one done pulse; draw_valid_in asserted the same cycle is not accepted.
REQ-028 rst_in asserted during the RD_R wait of a draw -> mem_valid_out=0 in the same cycle, no done_out pulse, draw_ready_out=1 after reset is released.
